// File: rtl/dual_port_ram_if.sv
// Write/read bus of the simple dual-port RAM.
//   master: drives write enable/address/data and read address, receives read data
//   slave : the RAM side
interface dual_port_ram_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  WrEn_SI;
   logic [ADDR_WIDTH-1:0] WrAddr_DI;
   logic [DATA_WIDTH-1:0] WrData_DI;
   logic [ADDR_WIDTH-1:0] RdAddr_DI;
   logic [DATA_WIDTH-1:0] RdData_DO;

   modport master (
      output WrEn_SI,
      output WrAddr_DI,
      output WrData_DI,
      output RdAddr_DI,
      input  RdData_DO
   );

   modport slave (
      input  WrEn_SI,
      input  WrAddr_DI,
      input  WrData_DI,
      input  RdAddr_DI,
      output RdData_DO
   );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one independent read port, single clock.
// SYNC_READ=0 gives a combinational read, SYNC_READ=1 a one-cycle registered,
// write-first read.
//   clk_i  : clock, writes and registered reads on the rising edge
//   rst_ni : asynchronous active-low reset, clears every word and the read register
//   bus    : WrEn_SI/WrAddr_DI/WrData_DI write port, RdAddr_DI/RdData_DO read port
module dual_port_ram #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_DEPTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SYNC_READ  = 0
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   dual_port_ram_if.slave bus
);

   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] rd_word_c;
   logic                  rd_in_range_c;

   // Storage array; out-of-range write addresses match no word and are dropped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DATA_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(DATA_DEPTH); i++) begin
            if (bus.WrEn_SI && (bus.WrAddr_DI == ADDR_WIDTH'(i))) begin
               mem_q[i] <= bus.WrData_DI;
            end
         end
      end
   end

   // Read mux; an address past the last word yields zero.
   always_comb begin
      rd_word_c     = '0;
      rd_in_range_c = 1'b0;
      for (int i = 0; i < int'(DATA_DEPTH); i++) begin
         if (bus.RdAddr_DI == ADDR_WIDTH'(i)) begin
            rd_word_c     = mem_q[i];
            rd_in_range_c = 1'b1;
         end
      end
   end

   if (SYNC_READ != 0) begin : g_sync_read
      logic                  bypass_c;
      logic [DATA_WIDTH-1:0] rd_q;

      // Write-first: a same-address write at this edge forwards the new word.
      assign bypass_c = bus.WrEn_SI && rd_in_range_c && (bus.WrAddr_DI == bus.RdAddr_DI);

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rd_q <= '0;
         end else begin
            rd_q <= bypass_c ? bus.WrData_DI : rd_word_c;
         end
      end

      assign bus.RdData_DO = rd_q;
   end else begin : g_async_read
      assign bus.RdData_DO = rd_word_c;
   end

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed testbench for dual_port_ram: async and sync read at depth 16,
// plus a non-power-of-two depth of 6 in both read modes.
module tb_dual_port_ram;

   logic clk;
   logic rst_n;

   int n_vec;
   int n_err;

   dual_port_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_a ();
   dual_port_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_s ();
   dual_port_ram_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus_na ();
   dual_port_ram_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus_ns ();

   dual_port_ram #(.ADDR_WIDTH(4), .DATA_DEPTH(16), .DATA_WIDTH(32), .SYNC_READ(0)) u_async (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus_a.slave));
   dual_port_ram #(.ADDR_WIDTH(4), .DATA_DEPTH(16), .DATA_WIDTH(32), .SYNC_READ(1)) u_sync (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus_s.slave));
   dual_port_ram #(.ADDR_WIDTH(3), .DATA_DEPTH(6), .DATA_WIDTH(32), .SYNC_READ(0)) u_np_async (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus_na.slave));
   dual_port_ram #(.ADDR_WIDTH(3), .DATA_DEPTH(6), .DATA_WIDTH(32), .SYNC_READ(1)) u_np_sync (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus_ns.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus_a.WrEn_SI  = 1'b0; bus_a.WrAddr_DI  = '0; bus_a.WrData_DI  = '0; bus_a.RdAddr_DI  = '0;
      bus_s.WrEn_SI  = 1'b0; bus_s.WrAddr_DI  = '0; bus_s.WrData_DI  = '0; bus_s.RdAddr_DI  = '0;
      bus_na.WrEn_SI = 1'b0; bus_na.WrAddr_DI = '0; bus_na.WrData_DI = '0; bus_na.RdAddr_DI = '0;
      bus_ns.WrEn_SI = 1'b0; bus_ns.WrAddr_DI = '0; bus_ns.WrData_DI = '0; bus_ns.RdAddr_DI = '0;
   endtask

   task automatic test_reset();
      // Put known nonzero data at addr 1 in both depth-16 RAMs.
      bus_a.WrEn_SI = 1'b1; bus_a.WrAddr_DI = 4'd1; bus_a.WrData_DI = 32'hDEAD_BEEF;
      bus_s.WrEn_SI = 1'b1; bus_s.WrAddr_DI = 4'd1; bus_s.WrData_DI = 32'hDEAD_BEEF;
      tick();
      bus_a.WrEn_SI = 1'b0; bus_s.WrEn_SI = 1'b0;
      bus_a.RdAddr_DI = 4'd1; bus_s.RdAddr_DI = 4'd1;
      tick();
      n_vec++;
      if (bus_a.RdData_DO !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL pre_reset_async: got %h exp %h", bus_a.RdData_DO, 32'hDEAD_BEEF);
      end
      n_vec++;
      if (bus_s.RdData_DO !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL pre_reset_sync: got %h exp %h", bus_s.RdData_DO, 32'hDEAD_BEEF);
      end
      // Mid-cycle reset with a write to addr 2 pending.
      #3;
      bus_a.WrEn_SI = 1'b1; bus_a.WrAddr_DI = 4'd2; bus_a.WrData_DI = 32'h5555_5555;
      bus_s.WrEn_SI = 1'b1; bus_s.WrAddr_DI = 4'd2; bus_s.WrData_DI = 32'h5555_5555;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus_a.RdData_DO !== 32'h0) begin
         n_err++; $display("FAIL reset_immediate_async: got %h exp %h", bus_a.RdData_DO, 32'h0);
      end
      n_vec++;
      if (bus_s.RdData_DO !== 32'h0) begin
         n_err++; $display("FAIL reset_immediate_sync: got %h exp %h", bus_s.RdData_DO, 32'h0);
      end
      // Hold reset across an edge with the write still asserted.
      tick();
      #2;
      bus_a.WrEn_SI = 1'b0; bus_s.WrEn_SI = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus_a.RdAddr_DI = 4'(i);
         bus_s.RdAddr_DI = 4'(i);
         tick();
         n_vec++;
         if (bus_a.RdData_DO !== 32'h0) begin
            n_err++; $display("FAIL reset_clear_async[%0d]: got %h exp %h", i, bus_a.RdData_DO, 32'h0);
         end
         n_vec++;
         if (bus_s.RdData_DO !== 32'h0) begin
            n_err++; $display("FAIL reset_clear_sync[%0d]: got %h exp %h", i, bus_s.RdData_DO, 32'h0);
         end
      end
   endtask

   task automatic test_write_readback();
      for (int i = 0; i < 16; i++) begin
         bus_a.WrEn_SI = 1'b1; bus_a.WrAddr_DI = 4'(i); bus_a.WrData_DI = 32'hA5A5_0000 + 32'(i);
         bus_s.WrEn_SI = 1'b1; bus_s.WrAddr_DI = 4'(i); bus_s.WrData_DI = 32'hA5A5_0000 + 32'(i);
         tick();
      end
      bus_a.WrEn_SI = 1'b0; bus_s.WrEn_SI = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         bus_a.RdAddr_DI = 4'(i);
         #1;
         n_vec++;
         if (bus_a.RdData_DO !== 32'hA5A5_0000 + 32'(i)) begin
            n_err++; $display("FAIL readback_async[%0d]: got %h exp %h", i, bus_a.RdData_DO, 32'hA5A5_0000 + 32'(i));
         end
      end
   endtask

   task automatic test_write_disabled();
      bus_a.WrEn_SI = 1'b0; bus_a.WrAddr_DI = 4'd4; bus_a.WrData_DI = 32'hCAFE_F00D;
      bus_a.RdAddr_DI = 4'd4;
      tick();
      n_vec++;
      if (bus_a.RdData_DO !== 32'hA5A5_0004) begin
         n_err++; $display("FAIL wren_low: got %h exp %h", bus_a.RdData_DO, 32'hA5A5_0004);
      end
   endtask

   task automatic test_latency();
      bus_s.RdAddr_DI = 4'd0;
      tick();
      bus_s.RdAddr_DI = 4'd3;
      #2;
      n_vec++;
      if (bus_s.RdData_DO !== 32'hA5A5_0000) begin
         n_err++; $display("FAIL latency_before3: got %h exp %h", bus_s.RdData_DO, 32'hA5A5_0000);
      end
      tick();
      n_vec++;
      if (bus_s.RdData_DO !== 32'hA5A5_0003) begin
         n_err++; $display("FAIL latency_after3: got %h exp %h", bus_s.RdData_DO, 32'hA5A5_0003);
      end
      bus_s.RdAddr_DI = 4'd7;
      #2;
      n_vec++;
      if (bus_s.RdData_DO !== 32'hA5A5_0003) begin
         n_err++; $display("FAIL latency_hold3: got %h exp %h", bus_s.RdData_DO, 32'hA5A5_0003);
      end
      tick();
      n_vec++;
      if (bus_s.RdData_DO !== 32'hA5A5_0007) begin
         n_err++; $display("FAIL latency_after7: got %h exp %h", bus_s.RdData_DO, 32'hA5A5_0007);
      end
   endtask

   task automatic test_collision();
      bus_a.WrEn_SI = 1'b1; bus_a.WrAddr_DI = 4'd5; bus_a.WrData_DI = 32'h11;
      bus_s.WrEn_SI = 1'b1; bus_s.WrAddr_DI = 4'd5; bus_s.WrData_DI = 32'h11;
      tick();
      bus_a.WrData_DI = 32'h22; bus_a.RdAddr_DI = 4'd5;
      bus_s.WrData_DI = 32'h22; bus_s.RdAddr_DI = 4'd5;
      #1;
      n_vec++;
      if (bus_a.RdData_DO !== 32'h11) begin
         n_err++; $display("FAIL collide_async_old: got %h exp %h", bus_a.RdData_DO, 32'h11);
      end
      tick();
      n_vec++;
      if (bus_a.RdData_DO !== 32'h22) begin
         n_err++; $display("FAIL collide_async_new: got %h exp %h", bus_a.RdData_DO, 32'h22);
      end
      n_vec++;
      if (bus_s.RdData_DO !== 32'h22) begin
         n_err++; $display("FAIL collide_sync_wfirst: got %h exp %h", bus_s.RdData_DO, 32'h22);
      end
      bus_a.WrEn_SI = 1'b0; bus_s.WrEn_SI = 1'b0;
   endtask

   task automatic test_non_pow2();
      for (int i = 0; i < 6; i++) begin
         bus_na.WrEn_SI = 1'b1; bus_na.WrAddr_DI = 3'(i); bus_na.WrData_DI = 32'h100 + 32'(i);
         bus_ns.WrEn_SI = 1'b1; bus_ns.WrAddr_DI = 3'(i); bus_ns.WrData_DI = 32'h100 + 32'(i);
         tick();
      end
      for (int i = 6; i < 8; i++) begin
         bus_na.WrAddr_DI = 3'(i); bus_na.WrData_DI = 32'hFF;
         bus_ns.WrAddr_DI = 3'(i); bus_ns.WrData_DI = 32'hFF;
         tick();
      end
      bus_na.WrEn_SI = 1'b0; bus_ns.WrEn_SI = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus_na.RdAddr_DI = 3'(i);
         bus_ns.RdAddr_DI = 3'(i);
         tick();
         n_vec++;
         if (bus_na.RdData_DO !== ((i < 6) ? 32'h100 + 32'(i) : 32'h0)) begin
            n_err++; $display("FAIL np_async[%0d]: got %h exp %h", i, bus_na.RdData_DO,
                              (i < 6) ? 32'h100 + 32'(i) : 32'h0);
         end
         n_vec++;
         if (bus_ns.RdData_DO !== ((i < 6) ? 32'h100 + 32'(i) : 32'h0)) begin
            n_err++; $display("FAIL np_sync[%0d]: got %h exp %h", i, bus_ns.RdData_DO,
                              (i < 6) ? 32'h100 + 32'(i) : 32'h0);
         end
      end
      // Out-of-range write and read at the same edge must not forward.
      bus_ns.WrEn_SI = 1'b1; bus_ns.WrAddr_DI = 3'd6; bus_ns.WrData_DI = 32'hFF;
      bus_ns.RdAddr_DI = 3'd6;
      tick();
      n_vec++;
      if (bus_ns.RdData_DO !== 32'h0) begin
         n_err++; $display("FAIL np_sync_oob_collide: got %h exp %h", bus_ns.RdData_DO, 32'h0);
      end
      bus_ns.WrEn_SI = 1'b0;
   endtask

   task automatic test_independent();
      bus_s.WrEn_SI = 1'b1; bus_s.WrAddr_DI = 4'd9; bus_s.WrData_DI = 32'h1234;
      tick();
      bus_s.WrAddr_DI = 4'd2; bus_s.WrData_DI = 32'hBEEF; bus_s.RdAddr_DI = 4'd9;
      tick();
      n_vec++;
      if (bus_s.RdData_DO !== 32'h1234) begin
         n_err++; $display("FAIL indep_read9: got %h exp %h", bus_s.RdData_DO, 32'h1234);
      end
      bus_s.WrEn_SI = 1'b0; bus_s.RdAddr_DI = 4'd2;
      tick();
      n_vec++;
      if (bus_s.RdData_DO !== 32'hBEEF) begin
         n_err++; $display("FAIL indep_read2: got %h exp %h", bus_s.RdData_DO, 32'hBEEF);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle_all();
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      test_reset();
      test_write_readback();
      test_write_disabled();
      test_latency();
      test_collision();
      test_non_pow2();
      test_independent();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
